spi_regfile_periph: RTL

//  Parametrised SPI peripheral register file: successor of the write-only 5-register SPI block.

---
 rtl/spi_regfile_periph.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_regfile_periph.sv
// SPI peripheral register file.
// Frames are MSB first: [R/W (1=write)] [ADDR] [DATA]. Writes commit when chip
// select rises after exactly one full frame; reads return the addressed
// register on MISO during the data phase. SCLK, NCS and MOSI are asynchronous
// and pass through synchronisers; all SPI timing is recovered from edges of the
// synchronised copies in the clk domain, so SCLK must be at most clk/8.
module spi_regfile_periph #(
   parameter int NUM_REGS    = 5,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sclk_i,
   input  logic                         ncs_i,
   input  logic                         mosi_i,
   output logic                         miso_o,
   output logic                         miso_oe_o,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic [NUM_REGS-1:0]          wr_stb_o,
   output logic                         frame_err_o
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 2);

   localparam logic [CNT_W-1:0]  CNT_CMD_END = CNT_W'(1 + ADDR_W);
   localparam logic [CNT_W-1:0]  CNT_FRAME   = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(FRAME_W + 1);
   localparam logic [ADDR_W:0]   ADDR_LIMIT  = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      DATA,
      DONE,
      OVERRUN
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ncs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_prev;
   logic                   ncs_prev;

   logic sclk_s;
   logic ncs_s;
   logic mosi_s;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ncs_s  = ncs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Synchronise the SPI pins and keep one previous sample for edge detection.
   // Reset values match the idle bus so that reset release creates no edge.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= {SYNC_STAGES{CPOL}};
         ncs_sync  <= '1;
         mosi_sync <= '0;
         sclk_prev <= CPOL;
         ncs_prev  <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
         sclk_prev <= sclk_s;
         ncs_prev  <= ncs_s;
      end
   end

   logic sclk_rise;
   logic sclk_fall;
   logic leading_edge;
   logic trailing_edge;
   logic sample_edge;
   logic shift_edge;
   logic ncs_fall;
   logic ncs_rise;

   assign sclk_rise     = sclk_s & ~sclk_prev;
   assign sclk_fall     = ~sclk_s & sclk_prev;
   assign leading_edge  = CPOL ? sclk_fall : sclk_rise;
   assign trailing_edge = CPOL ? sclk_rise : sclk_fall;
   // CPHA=0 samples on the leading edge and shifts on the trailing one;
   // CPHA=1 is the reverse.
   assign sample_edge   = CPHA ? trailing_edge : leading_edge;
   assign shift_edge    = CPHA ? leading_edge : trailing_edge;
   assign ncs_fall      = ~ncs_s & ncs_prev;
   assign ncs_rise      = ncs_s & ~ncs_prev;

   // ------------------------------------------------------------------
   // Frame state
   // ------------------------------------------------------------------
   state_t                state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [CNT_W-1:0]      cnt_inc;
   logic [FRAME_W-1:0]    rx_sh;
   logic [FRAME_W-1:0]    rx_next;
   logic [DATA_W-1:0]     tx_sh;
   logic [DATA_W-1:0]     regs_q [NUM_REGS];

   assign cnt_inc = bit_cnt + 1'b1;
   assign rx_next = {rx_sh[FRAME_W-2:0], mosi_s};

   // Fields of a completed frame, valid when bit_cnt == FRAME_W.
   logic                  frame_rw;
   logic [ADDR_W-1:0]     frame_addr;
   logic [DATA_W-1:0]     frame_data;
   logic                  frame_addr_ok;

   assign frame_rw      = rx_sh[FRAME_W-1];
   assign frame_addr    = rx_sh[FRAME_W-2 -: ADDR_W];
   assign frame_data    = rx_sh[DATA_W-1:0];
   assign frame_addr_ok = ({1'b0, frame_addr} < ADDR_LIMIT);

   // Register read mux; addresses outside the register file read as zero.
   function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
      read_reg = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (addr == ADDR_W'(k)) read_reg = regs_q[k];
      end
   endfunction

   // Frame FSM: bit counting, command decode, MISO shifting and the terminal
   // evaluation at chip-select rise (commit, error or silent discard).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         miso_o      <= 1'b0;
         miso_oe_o   <= 1'b0;
         wr_stb_o    <= '0;
         frame_err_o <= 1'b0;
         // NOTE: the register file is small and its reset contents are
         // architecturally visible on regs_o, so it is reset like any flop
         // instead of being treated as an unreset memory.
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      end else begin
         wr_stb_o    <= '0;
         frame_err_o <= 1'b0;
         miso_oe_o   <= ~ncs_s;

         if (ncs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx_sh   <= '0;
            miso_o  <= 1'b0;
            // A rise with no bits clocked is a select glitch: ignore it.
            if (bit_cnt != '0) begin
               if (bit_cnt != CNT_FRAME) begin
                  frame_err_o <= 1'b1;
               end else if (frame_rw) begin
                  if (frame_addr_ok) begin
                     for (int k = 0; k < NUM_REGS; k++) begin
                        if (frame_addr == ADDR_W'(k)) begin
                           regs_q[k]   <= frame_data;
                           wr_stb_o[k] <= 1'b1;
                        end
                     end
                  end else begin
                     frame_err_o <= 1'b1;
                  end
               end
            end
         end else if (ncs_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            miso_o  <= 1'b0;
         end else if (state == IDLE) begin
            bit_cnt <= '0;
            miso_o  <= 1'b0;
         end else begin
            if (sample_edge) begin
               rx_sh <= rx_next;
               if (bit_cnt != CNT_SAT) bit_cnt <= cnt_inc;
               case (state)
                  CMD: begin
                     if (cnt_inc == CNT_CMD_END) begin
                        state <= DATA;
                        // Writes shift out zeros; reads shift out reg[ADDR].
                        tx_sh <= rx_next[ADDR_W] ? '0 : read_reg(rx_next[ADDR_W-1:0]);
                     end
                  end
                  DATA: begin
                     if (cnt_inc == CNT_FRAME) state <= DONE;
                  end
                  DONE:    state <= OVERRUN;
                  default: state <= state;
               endcase
            end
            if (shift_edge) begin
               if (state == CMD) begin
                  miso_o <= 1'b0;
               end else begin
                  miso_o <= tx_sh[DATA_W-1];
                  tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
               end
            end
         end
      end
   end

   // Flatten the register file onto the output bus.
   // NOTE: always_comb assigns a default before the loop so no path can leave
   // a bit unassigned and infer a latch.
   always_comb begin
      regs_o = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_o[k*DATA_W +: DATA_W] = regs_q[k];
      end
   end

endmodule
